// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, format classes,
// error codes, FSM states and an opcode-to-format helper.
package instr_encoder_pkg;

   // Opcodes accepted by the encoder (same values the CPU control decoder uses)
   localparam logic [5:0] OP_ADD  = 6'h20;
   localparam logic [5:0] OP_SUB  = 6'h22;
   localparam logic [5:0] OP_OR   = 6'h25;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;

   // Error codes reported on o_err
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_IMM     = 2'b10;
   localparam logic [1:0] ERR_OVF     = 2'b11;

   typedef enum logic [1:0] {
      FMT_R,
      FMT_I,
      FMT_J,
      FMT_BAD
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE,
      ST_ERR
   } state_e;

   // Classify an opcode into its encoding format; unknown opcodes map to FMT_BAD
   function automatic fmt_e fmtOf(input logic [5:0] op);
      fmt_e fmt;
      case (op)
         OP_ADD, OP_SUB, OP_OR:            fmt = FMT_R;
         OP_LW, OP_SW, OP_ADDI, OP_BEQ:    fmt = FMT_I;
         OP_J:                             fmt = FMT_J;
         default:                          fmt = FMT_BAD;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Host-side stream and imem write-port bundle for the instruction encoder.
// The host drives the master side; the encoder uses the slave side.
interface instr_encoder_if #(parameter int ADDR_W = 8);

   logic              i_start;
   logic              i_valid;
   logic              o_ready;
   logic [5:0]        i_op;
   logic [2:0]        i_rs;
   logic [2:0]        i_rt;
   logic [2:0]        i_rd;
   logic [9:0]        i_imm;
   logic              i_last;
   logic              o_memWe;
   logic [ADDR_W-1:0] o_memAddr;
   logic [15:0]       o_memData;
   logic              o_busy;
   logic              o_done;
   logic [1:0]        o_err;
   logic [ADDR_W:0]   o_count;

   modport master (
      output i_start, i_valid, i_op, i_rs, i_rt, i_rd, i_imm, i_last,
      input  o_ready, o_memWe, o_memAddr, o_memData, o_busy, o_done, o_err, o_count
   );

   modport slave (
      input  i_start, i_valid, i_op, i_rs, i_rt, i_rd, i_imm, i_last,
      output o_ready, o_memWe, o_memAddr, o_memData, o_busy, o_done, o_err, o_count
   );

endinterface

// File: rtl/instr_encoder_field_packer.sv
// Combinational packer: turns an opcode plus register/immediate fields into a
// 16-bit instruction word and flags illegal opcodes and out-of-range immediates.
module instr_field_packer
   import instr_encoder_pkg::*;
(
   input  logic [5:0]  op_i,
   input  logic [2:0]  rs_i,
   input  logic [2:0]  rt_i,
   input  logic [2:0]  rd_i,
   input  logic [9:0]  imm_i,
   output logic [15:0] word_o,
   output logic        isLegal_o,
   output logic        immOk_o
);

   // Pack by format; I-type immediates must sign-extend cleanly from 4 bits
   always_comb begin
      word_o    = '0;
      isLegal_o = 1'b1;
      immOk_o   = 1'b1;
      case (fmtOf(op_i))
         FMT_R: word_o = {op_i, rs_i, rt_i, rd_i, 1'b0};
         FMT_I: begin
            word_o  = {op_i, rs_i, rt_i, imm_i[3:0]};
            immOk_o = (imm_i[9:4] == {6{imm_i[3]}});
         end
         FMT_J: word_o = {op_i, imm_i};
         default: isLegal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: accepts symbolic instructions on a valid/ready
// stream, packs them into 16-bit words and writes them sequentially to imem.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 8
)
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   instr_encoder_if.slave  bus
);

   localparam logic [ADDR_W-1:0] PTR_MAX = '1;

   logic [1:0]        rstSync_q;
   logic              rstN;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              memWe_q, memWe_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [15:0]       memData_q, memData_d;
   logic [1:0]        err_q, err_d;

   logic [15:0]       packedWord;
   logic              isLegal;
   logic              immOk;
   logic              accept;

   instr_field_packer u_packer (
      .op_i      (bus.i_op),
      .rs_i      (bus.i_rs),
      .rt_i      (bus.i_rt),
      .rd_i      (bus.i_rd),
      .imm_i     (bus.i_imm),
      .word_o    (packedWord),
      .isLegal_o (isLegal),
      .immOk_o   (immOk)
   );

   // Reset asserts immediately but releases only after two clean clock edges
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rstSync_q <= 2'b00;
      end else begin
         rstSync_q <= {rstSync_q[0], 1'b1};
      end
   end

   assign rstN   = rstSync_q[1];
   assign accept = bus.i_valid && (state_q == ST_RUN);

   // State, pointer and output registers
   always_ff @(posedge i_clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= ST_IDLE;
         wrPtr_q   <= '0;
         count_q   <= '0;
         memWe_q   <= 1'b0;
         memAddr_q <= '0;
         memData_q <= '0;
         err_q     <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         wrPtr_q   <= wrPtr_d;
         count_q   <= count_d;
         memWe_q   <= memWe_d;
         memAddr_q <= memAddr_d;
         memData_q <= memData_d;
         err_q     <= err_d;
      end
   end

   // Next state: start always wins, then an accepted word is checked and written
   always_comb begin
      state_d   = state_q;
      wrPtr_d   = wrPtr_q;
      count_d   = count_q;
      memWe_d   = 1'b0;
      memAddr_d = memAddr_q;
      memData_d = memData_q;
      err_d     = err_q;
      if (bus.i_start) begin
         state_d   = ST_RUN;
         wrPtr_d   = '0;
         count_d   = '0;
         memAddr_d = '0;
         memData_d = '0;
         err_d     = ERR_NONE;
      end else if (accept) begin
         if (!isLegal) begin
            state_d = ST_ERR;
            err_d   = ERR_ILLEGAL;
         end else if (!immOk) begin
            state_d = ST_ERR;
            err_d   = ERR_IMM;
         end else begin
            memWe_d   = 1'b1;
            memAddr_d = wrPtr_q;
            memData_d = packedWord;
            count_d   = count_q + 1'b1;
            if (wrPtr_q != PTR_MAX) begin
               wrPtr_d = wrPtr_q + 1'b1;
            end
            if (bus.i_last) begin
               state_d = ST_DONE;
            end else if (wrPtr_q == PTR_MAX) begin
               state_d = ST_ERR;
               err_d   = ERR_OVF;
            end
         end
      end
   end

   assign bus.o_ready   = (state_q == ST_RUN);
   assign bus.o_busy    = (state_q == ST_RUN);
   assign bus.o_done    = (state_q == ST_DONE);
   assign bus.o_memWe   = memWe_q;
   assign bus.o_memAddr = memAddr_q;
   assign bus.o_memData = memData_q;
   assign bus.o_err     = err_q;
   assign bus.o_count   = count_q;

endmodule
